mux_16bit_sel: RTL and testbench

Two-input, 16-bit word selector for the single-cycle datapath. It chooses between operand X (select=0) and operand Y (select=1), e.g. register-vs-immediate or ALU-vs-memory write-back. It provides both a zero-latency combinational result and a registered copy for pipelined or debug consumers.

---
 rtl/mux_16bit_sel.sv | 48 ++++
 tb/tb_mux_16bit_sel.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_16bit_sel.sv
// Two-input word selector for the single-cycle datapath.
// Z is the zero-latency combinational choice between X (select=0) and
// Y (select=1). Z_q is a registered copy loaded when en is high, and
// changed pulses for one cycle after a load that altered Z_q.
module mux_16bit_sel #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             select,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             en,
    output logic [WIDTH-1:0] Z,
    output logic [WIDTH-1:0] Z_q,
    output logic             changed
);

    logic [WIDTH-1:0] z_q_d;
    logic             changed_d;

    // Combinational word select, live even while reset is asserted.
    always_comb begin
        Z = select ? Y : X;
    end

    // Next-state: load the selected word on en, otherwise hold and drop the pulse.
    always_comb begin
        z_q_d     = Z_q;
        changed_d = 1'b0;
        if (en) begin
            z_q_d     = Z;
            changed_d = (Z != Z_q);
        end
    end

    // Registered copy and change pulse; reset clears both immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Z_q     <= '0;
            changed <= 1'b0;
        end else begin
            Z_q     <= z_q_d;
            changed <= changed_d;
        end
    end

endmodule

// File: tb/tb_mux_16bit_sel.sv
// Self-checking bench for mux_16bit_sel: directed scenarios followed by
// randomized traffic checked against a behavioural model.
module tb_mux_16bit_sel;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             select = 1'b0;
    logic [WIDTH-1:0] X = '0;
    logic [WIDTH-1:0] Y = '0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] Z;
    logic [WIDTH-1:0] Z_q;
    logic             changed;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the registered state.
    logic [WIDTH-1:0] mq = '0;
    logic             mc = 1'b0;

    mux_16bit_sel #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .select  (select),
        .X       (X),
        .Y       (Y),
        .en      (en),
        .Z       (Z),
        .Z_q     (Z_q),
        .changed (changed)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] pick(input logic s, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        return s ? b : a;
    endfunction

    // Advance one rising edge, update the model from the inputs present at
    // that edge, and leave time 1 unit after the edge for sampling.
    task automatic tick();
        logic [WIDTH-1:0] zs;
        logic             en_s;
        logic             rst_s;
        zs    = pick(select, X, Y);
        en_s  = en;
        @(posedge clk);
        rst_s = reset;
        if (rst_s) begin
            mq = '0;
            mc = 1'b0;
        end else if (en_s) begin
            mc = (zs != mq);
            mq = zs;
        end else begin
            mc = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        select = 1'b0; X = '0; Y = '0; en = 1'b0;
        reset = 1'b1;
        mq = '0; mc = 1'b0;
        #1;
        n_tests++;
        if (Z !== 16'h0000) begin n_fail++; $display("FAIL reset_Z got=%h exp=0000", Z); end
        n_tests++;
        if (Z_q !== 16'h0000) begin n_fail++; $display("FAIL reset_Zq got=%h exp=0000", Z_q); end
        n_tests++;
        if (changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed got=%b exp=0", changed); end
        #100;
        n_tests++;
        if (Z_q !== 16'h0000 || changed !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold got Zq=%h chg=%b exp Zq=0000 chg=0", Z_q, changed);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (Z_q !== 16'h0000 || changed !== 1'b0) begin
            n_fail++; $display("FAIL reset_release got Zq=%h chg=%b exp Zq=0000 chg=0", Z_q, changed);
        end
    endtask

    task automatic test_select_x();
        X = 16'd16; Y = 16'd23; select = 1'b0; en = 1'b1;
        #1;
        n_tests++;
        if (Z !== 16'h0010) begin n_fail++; $display("FAIL selx_Z got=%h exp=0010", Z); end
        tick();
        n_tests++;
        if (Z_q !== 16'h0010 || changed !== 1'b1) begin
            n_fail++; $display("FAIL selx_load got Zq=%h chg=%b exp Zq=0010 chg=1", Z_q, changed);
        end
        en = 1'b0;
        tick();
        n_tests++;
        if (Z_q !== 16'h0010 || changed !== 1'b0) begin
            n_fail++; $display("FAIL selx_pulse_end got Zq=%h chg=%b exp Zq=0010 chg=0", Z_q, changed);
        end
    endtask

    task automatic test_select_y();
        select = 1'b1;
        #1;
        n_tests++;
        if (Z !== 16'h0017 || Z_q !== 16'h0010) begin
            n_fail++; $display("FAIL sely_comb got Z=%h Zq=%h exp Z=0017 Zq=0010", Z, Z_q);
        end
        en = 1'b1;
        tick();
        n_tests++;
        if (Z_q !== 16'h0017 || changed !== 1'b1) begin
            n_fail++; $display("FAIL sely_load got Zq=%h chg=%b exp Zq=0017 chg=1", Z_q, changed);
        end
    endtask

    task automatic test_switch_back();
        select = 1'b0; en = 1'b0;
        #1;
        n_tests++;
        if (Z !== 16'h0010) begin n_fail++; $display("FAIL swb_Z got=%h exp=0010", Z); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (Z_q !== 16'h0017 || changed !== 1'b0) begin
                n_fail++; $display("FAIL swb_hold%0d got Zq=%h chg=%b exp Zq=0017 chg=0", i, Z_q, changed);
            end
        end
    endtask

    task automatic test_equal_reload();
        X = 16'hFFFF; Y = 16'hFFFF; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            select = i[0];
            #1;
            n_tests++;
            if (Z !== 16'hFFFF) begin n_fail++; $display("FAIL eq_Z%0d got=%h exp=ffff", i, Z); end
            tick();
            n_tests++;
            if (Z_q !== 16'hFFFF || changed !== (i == 0)) begin
                n_fail++; $display("FAIL eq_load%0d got Zq=%h chg=%b exp Zq=ffff chg=%b", i, Z_q, changed, (i == 0));
            end
        end
    endtask

    task automatic test_async_reset();
        X = 16'hA5A5; Y = 16'h1234; select = 1'b0; en = 1'b1;
        tick();
        n_tests++;
        if (Z_q !== 16'hA5A5 || changed !== 1'b1) begin
            n_fail++; $display("FAIL ar_preload got Zq=%h chg=%b exp Zq=a5a5 chg=1", Z_q, changed);
        end
        #2;
        reset = 1'b1;
        mq = '0; mc = 1'b0;
        #1;
        n_tests++;
        if (Z_q !== 16'h0000 || changed !== 1'b0) begin
            n_fail++; $display("FAIL ar_immediate got Zq=%h chg=%b exp Zq=0000 chg=0", Z_q, changed);
        end
        n_tests++;
        if (Z !== 16'hA5A5) begin n_fail++; $display("FAIL ar_Z got=%h exp=a5a5", Z); end
        tick();
        n_tests++;
        if (Z_q !== 16'h0000) begin n_fail++; $display("FAIL ar_held got Zq=%h exp=0000", Z_q); end
        #2;
        reset = 1'b0;
        tick();
        n_tests++;
        if (Z_q !== 16'hA5A5 || changed !== 1'b1) begin
            n_fail++; $display("FAIL ar_first_load got Zq=%h chg=%b exp Zq=a5a5 chg=1", Z_q, changed);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ez;
        for (int i = 0; i < 300; i++) begin
            select = 1'($urandom);
            en     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                X = 16'($urandom_range(0, 2));
                Y = 16'($urandom_range(0, 2));
            end else begin
                X = 16'($urandom);
                Y = 16'($urandom);
            end
            #1;
            ez = pick(select, X, Y);
            n_tests++;
            if (Z !== ez) begin n_fail++; $display("FAIL rnd_Z%0d got=%h exp=%h", i, Z, ez); end
            tick();
            n_tests++;
            if (Z_q !== mq || changed !== mc) begin
                n_fail++; $display("FAIL rnd_reg%0d got Zq=%h chg=%b exp Zq=%h chg=%b", i, Z_q, changed, mq, mc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_select_x();
        test_select_y();
        test_switch_back();
        test_equal_reload();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
